noc_packet_demux: RTL and testbench

- Flit-level NoC demultiplexer: routes packets from one input link to one of CHANNELS output links.
- Output selection is per packet, from the 3-bit packet class in the header flit, looked up in the MAPPING parameter.
- Sits between a router/local port and class-specific endpoints (e.g. DMA, message passing). Zero-latency pass-through of flit data; only the routing decision is stateful.

---
 rtl/noc_packet_demux.sv | 83 ++++++++
 tb/tb_noc_packet_demux.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/noc_packet_demux.sv
// noc_packet_demux: routes whole packets from one input link to one of
// CHANNELS output links. Flit data, valid and ready pass through with zero
// latency; the only state is the one-hot mask of the channel that owns the
// packet currently in flight.
//
// Handshake: on every link a flit moves when valid and ready are both high at
// the rising edge of clk. Valid never depends on ready of the same link.
// Upstream ready may depend combinationally on the class bits of the flit
// while no packet is in flight.
module noc_packet_demux #(
   parameter int          FLIT_WIDTH = 34,
   parameter int          CHANNELS   = 2,
   parameter logic [63:0] MAPPING    = 64'h0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [FLIT_WIDTH-1:0]          in_flit,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic [CHANNELS*FLIT_WIDTH-1:0] out_flit,
   output logic [CHANNELS-1:0]            out_valid,
   input  logic [CHANNELS-1:0]            out_ready
);

   localparam logic [1:0] TYPE_PAYLOAD = 2'b00;
   localparam logic [1:0] TYPE_HEADER  = 2'b01;
   localparam logic [1:0] TYPE_LAST    = 2'b10;

   // Owning channel of the packet in flight; all-zero means idle.
   logic [CHANNELS-1:0] r_active;

   logic [1:0]          w_type;
   logic [2:0]          w_class;
   logic [CHANNELS-1:0] w_map_sel;
   logic [CHANNELS-1:0] w_idle_sel;
   logic [CHANNELS-1:0] w_sel;
   logic                w_idle;
   logic                w_accept;

   assign w_type   = in_flit[33:32];
   assign w_class  = in_flit[26:24];
   assign w_idle   = (r_active == '0);
   assign w_accept = in_valid & in_ready;

   // Look up the class mask in the routing table (low CHANNELS bits per byte).
   always_comb begin
      w_map_sel = '0;
      for (int c = 0; c < 8; c++) begin
         if (w_class == 3'(c)) begin
            w_map_sel = MAPPING[8*c +: CHANNELS];
         end
      end
   end

   // An unmapped class falls back to channel 0 so it can never stall the link.
   assign w_idle_sel = (w_map_sel == '0) ? CHANNELS'(1) : w_map_sel;

   // A packet in flight keeps its channel regardless of later class bits.
   assign w_sel = w_idle ? w_idle_sel : r_active;

   // Every channel sees the input flit; only the selected one sees valid.
   assign out_flit  = {CHANNELS{in_flit}};
   assign out_valid = w_sel & {CHANNELS{in_valid}};
   assign in_ready  = |(w_sel & out_ready);

   // Track packet ownership: a header claims the channel while idle, LAST
   // releases it. Headers while busy are treated as payload; SINGLE and
   // PAYLOAD leave the owner unchanged.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_active <= '0;
      end else if (w_accept) begin
         if (w_type == TYPE_LAST) begin
            r_active <= '0;
         end else if (w_idle && (w_type == TYPE_HEADER)) begin
            r_active <= w_sel;
         end else if (w_type == TYPE_PAYLOAD) begin
            r_active <= r_active;
         end
      end
   end

endmodule

// File: tb/tb_noc_packet_demux.sv
// Bench for noc_packet_demux with 3 channels and the class0->ch0,
// class1->ch1, class2->ch2 table (classes 3..7 unmapped). A packet-level
// reference model (owner channel index, -1 when idle) predicts valid, ready
// and data for each directed and random step.
module tb_noc_packet_demux;

  localparam int          FW  = 34;
  localparam int          CH  = 3;
  localparam logic [63:0] MAP = 64'h0000_0000_0004_0201;

  localparam logic [1:0] T_PAY = 2'b00;
  localparam logic [1:0] T_HDR = 2'b01;
  localparam logic [1:0] T_LST = 2'b10;
  localparam logic [1:0] T_SGL = 2'b11;

  logic             clk;
  logic             rst;
  logic [FW-1:0]    in_flit;
  logic             in_valid;
  logic             in_ready;
  logic [CH*FW-1:0] out_flit;
  logic [CH-1:0]    out_valid;
  logic [CH-1:0]    out_ready;

  noc_packet_demux #(
    .FLIT_WIDTH (FW),
    .CHANNELS   (CH),
    .MAPPING    (MAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_flit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model state
  int map_tbl [8] = '{0, 1, 2, 0, 0, 0, 0, 0};
  int owner = -1;
  int n_cmp = 0;
  int n_bad = 0;
  int n_xfer = 0;
  logic [FW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] t, input logic [2:0] cls, input logic [23:0] d);
    logic [4:0] dst;
    dst = 5'($urandom_range(0, 31));
    return {t, dst, cls, d};
  endfunction

  // driver: apply one cycle of inputs, check combinational outputs against
  // the model, then advance the model past the clock edge
  task automatic step(input string tag, input logic [FW-1:0] f, input logic v,
                      input logic [CH-1:0] rdy, input logic r);
    int ch;
    logic [CH-1:0] exp_v;
    logic exp_r;
    logic acc;
    in_flit   = f;
    in_valid  = v;
    out_ready = rdy;
    rst       = r;
    #2;
    ch    = (owner >= 0) ? owner : map_tbl[f[26:24]];
    exp_v = v ? CH'(1 << ch) : '0;
    exp_r = rdy[ch];
    chk({tag, ".out_valid"}, 128'(out_valid), 128'(exp_v));
    chk({tag, ".in_ready"},  128'(in_ready),  128'(exp_r));
    chk({tag, ".out_flit"},  128'(out_flit[ch*FW +: FW]), 128'(f));
    acc = v && exp_r;
    if (acc) exp_q.push_back(f);
    @(posedge clk);
    #1;
    if (!r) begin
      owner = -1;
    end else if (acc) begin
      if (f[33:32] == T_LST) owner = -1;
      else if (owner < 0 && f[33:32] == T_HDR) owner = ch;
    end
  endtask

  // scoreboard: every accepted flit must appear on exactly one channel
  // with valid & ready at the same edge
  always @(posedge clk) begin
    if (rst !== 1'b0 || in_valid) begin
      for (int i = 0; i < CH; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          n_xfer++;
          if (exp_q.size() == 0) begin
            chk("sb.unexpected", 128'(out_flit[i*FW +: FW]), 128'(0));
          end else begin
            chk("sb.flit", 128'(out_flit[i*FW +: FW]), 128'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    logic [1:0] t;
    in_flit = '0; in_valid = 1'b0; out_ready = '0; rst = 1'b0;

    step("rst0", '0, 1'b0, 3'b111, 1'b0);
    step("rst1", '0, 1'b0, 3'b111, 1'b0);

    // idle, nothing valid: no output valid
    step("idle_novalid", mk(T_HDR, 3'd1, 24'h1), 1'b0, 3'b111, 1'b1);

    // unmapped class 5 single goes to channel 0
    step("single_c5", mk(T_SGL, 3'd5, 24'hA5A5A5), 1'b1, 3'b111, 1'b1);

    // packet on class 2, later flits carry class 0
    step("hdr_c2",  mk(T_HDR, 3'd2, 24'h000001), 1'b1, 3'b111, 1'b1);
    step("pay0_c2", mk(T_PAY, 3'd0, 24'h000002), 1'b1, 3'b111, 1'b1);
    step("pay1_c2", mk(T_PAY, 3'd0, 24'h000003), 1'b1, 3'b111, 1'b1);
    step("hdr_busy", mk(T_HDR, 3'd1, 24'h000004), 1'b1, 3'b111, 1'b1);
    step("last_c2", mk(T_LST, 3'd0, 24'h000005), 1'b1, 3'b111, 1'b1);
    step("after_last", mk(T_SGL, 3'd0, 24'h000006), 1'b1, 3'b111, 1'b1);

    // back-pressure on channel 1, then release
    step("bp_hold0", mk(T_HDR, 3'd1, 24'h000010), 1'b1, 3'b101, 1'b1);
    step("bp_hold1", mk(T_HDR, 3'd1, 24'h000010), 1'b1, 3'b101, 1'b1);
    step("bp_go",    mk(T_HDR, 3'd1, 24'h000010), 1'b1, 3'b111, 1'b1);
    step("bp_last",  mk(T_LST, 3'd2, 24'h000011), 1'b1, 3'b111, 1'b1);

    // back-to-back single then header, no bubble
    step("b2b_sgl", mk(T_SGL, 3'd0, 24'h000020), 1'b1, 3'b111, 1'b1);
    step("b2b_hdr", mk(T_HDR, 3'd1, 24'h000021), 1'b1, 3'b111, 1'b1);
    step("b2b_lst", mk(T_LST, 3'd2, 24'h000022), 1'b1, 3'b111, 1'b1);

    // reset mid-packet drops ownership
    step("mid_hdr", mk(T_HDR, 3'd2, 24'h000030), 1'b1, 3'b111, 1'b1);
    step("mid_rst", mk(T_PAY, 3'd1, 24'h000031), 1'b0, 3'b111, 1'b0);
    step("mid_pay", mk(T_PAY, 3'd1, 24'h000032), 1'b1, 3'b111, 1'b1);
    step("mid_lst_idle", mk(T_LST, 3'd2, 24'h000033), 1'b1, 3'b111, 1'b1);
    step("mid_after", mk(T_SGL, 3'd1, 24'h000034), 1'b1, 3'b111, 1'b1);

    // unmapped class 7
    step("single_c7", mk(T_SGL, 3'd7, 24'h000040), 1'b1, 3'b111, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      t = 2'($urandom_range(0, 3));
      step("rand", mk(t, 3'($urandom_range(0, 7)), 24'($urandom)),
           ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 39) != 0));
    end

    step("drain", '0, 1'b0, 3'b111, 1'b1);
    chk("sb.empty", 128'(exp_q.size()), 128'(0));
    $display("transfers observed: %0d", n_xfer);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
